// File: rtl/timer_int_ctrl_pkg.sv
// Shared definitions for the timer interrupt source: register window codes,
// CTRL/STATUS bit positions and the controller state encoding.
package timer_int_ctrl_pkg;

  // Controller states; encodings are fixed so they stay stable in waveforms.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_WAIT = 3'd2,
    S_FIRE = 3'd3,
    S_SVC  = 3'd4
  } tmr_state_e;

  // epce is asserted while the controller sits in this state.
  localparam tmr_state_e TIMER_INT_STATUS = S_FIRE;

  // cfg_addr register select codes.
  typedef enum logic [1:0] {
    TMR_CTRL   = 2'd0,
    TMR_PERIOD = 2'd1,
    TMR_COUNT  = 2'd2,
    TMR_STATUS = 2'd3
  } tmr_addr_e;

  // CTRL bit positions.
  localparam int unsigned CTRL_EN_BIT = 0;
  localparam int unsigned CTRL_AR_BIT = 1;

  // STATUS bit positions.
  localparam int unsigned STAT_PEND_BIT  = 0;
  localparam int unsigned STAT_INSVC_BIT = 1;
  localparam int unsigned STAT_OVR_BIT   = 2;
  localparam int unsigned STAT_W        = 3;

  // Assemble the STATUS field from its individual flags.
  function automatic logic [STAT_W-1:0] pack_status(input logic pend,
                                                    input logic insvc,
                                                    input logic ovr);
    logic [STAT_W-1:0] s;
    s                 = '0;
    s[STAT_PEND_BIT]  = pend;
    s[STAT_INSVC_BIT] = insvc;
    s[STAT_OVR_BIT]   = ovr;
    return s;
  endfunction

endpackage

// File: rtl/timer_int_ctrl_counter.sv
// Timer counter: holds EN, AUTO_RELOAD, PERIOD and COUNT, and produces a
// single-cycle match strobe when COUNT reaches PERIOD-1.
module timer_counter
  import timer_int_ctrl_pkg::*;
#(
  parameter int unsigned           CNT_W      = 32,
  parameter logic [CNT_W-1:0]      RST_PERIOD = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ctrl_we_i,
  input  logic             en_wdata_i,
  input  logic             ar_wdata_i,
  input  logic             period_we_i,
  input  logic [CNT_W-1:0] period_wdata_i,
  output logic             en_o,
  output logic             ar_o,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] count_o,
  output logic             match_o
);

  logic             en_q, en_d;
  logic             ar_q, ar_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             period_nz;
  logic [CNT_W-1:0] period_m1;
  logic             match;

  // PERIOD-1 only matters when PERIOD is non-zero; the zero case is gated out.
  assign period_nz = |period_q;
  assign period_m1 = period_q - CNT_W'(1);
  assign match     = en_q & period_nz & (count_q == period_m1);

  // Next-state for counter and config; later assignments take priority.
  always_comb begin
    en_d     = en_q;
    ar_d     = ar_q;
    period_d = period_q;
    count_d  = count_q;
    if (en_q && period_nz) begin
      count_d = count_q + CNT_W'(1);
    end
    if (match) begin
      count_d = '0;
      if (!ar_q) begin
        en_d = 1'b0;
      end
    end
    // A PERIOD write restarts the count; the current match still used the old PERIOD.
    if (period_we_i) begin
      period_d = period_wdata_i;
      count_d  = '0;
    end
    if (ctrl_we_i) begin
      en_d = en_wdata_i;
      ar_d = ar_wdata_i;
    end
  end

  // Counter and config registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q     <= 1'b0;
      ar_q     <= 1'b0;
      period_q <= RST_PERIOD;
      count_q  <= '0;
    end else begin
      en_q     <= en_d;
      ar_q     <= ar_d;
      period_q <= period_d;
      count_q  <= count_d;
    end
  end

  assign en_o     = en_q;
  assign ar_o     = ar_q;
  assign period_o = period_q;
  assign count_o  = count_q;
  assign match_o  = match;

endmodule

// File: rtl/timer_int_ctrl.sv
// Timer interrupt controller: register window, PEND/INSVC/OVR status,
// and the delivery FSM that emits the one-cycle epce pulse.
module timer_int_ctrl
  import timer_int_ctrl_pkg::*;
#(
  parameter int unsigned      CNT_W      = 32,
  parameter logic [CNT_W-1:0] RST_PERIOD = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [CNT_W-1:0] cfg_wdata,
  output logic [CNT_W-1:0] cfg_rdata,
  input  logic             eret,
  input  logic             stall,
  output logic             epce,
  output logic             int_pending,
  output logic             in_service
);

  tmr_state_e       state_q, state_d;
  logic             pend_q, pend_d;
  logic             insvc_q, insvc_d;
  logic             ovr_q, ovr_d;
  logic             pend_live;
  logic             fire;
  logic             ctrl_we, period_we, stat_we;
  logic             en, ar, match;
  logic [CNT_W-1:0] period, count;

  assign ctrl_we   = cfg_we && (tmr_addr_e'(cfg_addr) == TMR_CTRL);
  assign period_we = cfg_we && (tmr_addr_e'(cfg_addr) == TMR_PERIOD);
  assign stat_we   = cfg_we && (tmr_addr_e'(cfg_addr) == TMR_STATUS);

  timer_counter #(
    .CNT_W      (CNT_W),
    .RST_PERIOD (RST_PERIOD)
  ) u_counter (
    .clk_i          (clk),
    .rst_ni         (rst),
    .ctrl_we_i      (ctrl_we),
    .en_wdata_i     (cfg_wdata[CTRL_EN_BIT]),
    .ar_wdata_i     (cfg_wdata[CTRL_AR_BIT]),
    .period_we_i    (period_we),
    .period_wdata_i (cfg_wdata),
    .en_o           (en),
    .ar_o           (ar),
    .period_o       (period),
    .count_o        (count),
    .match_o        (match)
  );

  assign fire = (state_q == TIMER_INT_STATUS);

  // Status flags: FIRE consumes PEND first, then W1C, then a match sets PEND
  // (or OVR if an unconsumed interrupt is still pending), so a match always wins.
  always_comb begin
    pend_live = pend_q & ~fire;
    pend_d    = pend_live;
    ovr_d     = ovr_q;
    insvc_d   = insvc_q;
    if (stat_we && cfg_wdata[STAT_PEND_BIT]) begin
      pend_d = 1'b0;
    end
    if (stat_we && cfg_wdata[STAT_OVR_BIT]) begin
      ovr_d = 1'b0;
    end
    if (match) begin
      if (pend_live) begin
        ovr_d = 1'b1;
      end
      pend_d = 1'b1;
    end
    if (fire) begin
      insvc_d = 1'b1;
    end else if ((state_q == S_SVC) && eret) begin
      insvc_d = 1'b0;
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= 1'b0;
      insvc_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      insvc_q <= insvc_d;
      ovr_q   <= ovr_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; SVC looks at pend_d so an eret coinciding with a match
  // goes straight to WAIT and the pulse follows a cycle later.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RUN: begin
        if (match) begin
          state_d = S_WAIT;
        end else if (en) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!pend_q) begin
          state_d = match ? S_WAIT : (en ? S_RUN : S_IDLE);
        end else if (!stall && !insvc_q) begin
          state_d = S_FIRE;
        end
      end
      S_FIRE: begin
        state_d = S_SVC;
      end
      S_SVC: begin
        if (eret) begin
          state_d = pend_d ? S_WAIT : (en ? S_RUN : S_IDLE);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM outputs.
  always_comb begin
    epce        = fire;
    int_pending = pend_q;
    in_service  = insvc_q;
  end

  // Combinational register read.
  always_comb begin
    cfg_rdata = '0;
    case (tmr_addr_e'(cfg_addr))
      TMR_CTRL: begin
        cfg_rdata[CTRL_EN_BIT] = en;
        cfg_rdata[CTRL_AR_BIT] = ar;
      end
      TMR_PERIOD: cfg_rdata = period;
      TMR_COUNT:  cfg_rdata = count;
      TMR_STATUS: cfg_rdata[STAT_W-1:0] = pack_status(pend_q, insvc_q, ovr_q);
      default:    cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Self-checking bench for timer_int_ctrl: a cycle-level behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_timer_int_ctrl;

  localparam int unsigned      CNT_W      = 32;
  localparam logic [CNT_W-1:0] RST_PERIOD = '0;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cfg_we = 1'b0;
  logic [1:0]       cfg_addr = 2'd0;
  logic [CNT_W-1:0] cfg_wdata = '0;
  logic [CNT_W-1:0] cfg_rdata;
  logic             eret = 1'b0;
  logic             stall = 1'b0;
  logic             epce, int_pending, in_service;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses[$];
  int t0;

  always #5 clk = ~clk;

  timer_int_ctrl #(
    .CNT_W      (CNT_W),
    .RST_PERIOD (RST_PERIOD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_rdata   (cfg_rdata),
    .eret        (eret),
    .stall       (stall),
    .epce        (epce),
    .int_pending (int_pending),
    .in_service  (in_service)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A pulse is owed while an interrupt is pending and not already being taken;
  // it is delivered the cycle after one with no stall and nothing in service.
  logic        m_en, m_ar, m_pend, m_insvc, m_ovr, m_epce;
  logic [31:0] m_period, m_count;
  logic        m_hit, m_owed, wr_ctrl, wr_per, wr_stat;
  logic [31:0] m_rdata;

  assign m_hit   = m_en && (m_period != 0) && (m_count == m_period - 32'd1);
  assign m_owed  = m_pend && !m_epce;
  assign wr_ctrl = cfg_we && (cfg_addr == 2'd0);
  assign wr_per  = cfg_we && (cfg_addr == 2'd1);
  assign wr_stat = cfg_we && (cfg_addr == 2'd3);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_en <= 0; m_ar <= 0; m_pend <= 0; m_insvc <= 0; m_ovr <= 0; m_epce <= 0;
      m_period <= RST_PERIOD; m_count <= 0;
    end else begin
      m_count  <= wr_per ? 32'd0 : m_hit ? 32'd0 : (m_en && m_period != 0) ? m_count + 1 : m_count;
      m_period <= wr_per ? cfg_wdata : m_period;
      m_en     <= wr_ctrl ? cfg_wdata[0] : (m_hit && !m_ar) ? 1'b0 : m_en;
      m_ar     <= wr_ctrl ? cfg_wdata[1] : m_ar;
      m_pend   <= m_hit || (m_owed && !(wr_stat && cfg_wdata[0]));
      m_ovr    <= (m_hit && m_owed) || (m_ovr && !(wr_stat && cfg_wdata[2]));
      m_insvc  <= m_epce || (m_insvc && !eret);
      m_epce   <= m_pend && !m_insvc && !m_epce && !stall;
    end
  end

  always_comb begin
    m_rdata = 32'd0;
    case (cfg_addr)
      2'd0: m_rdata = {30'd0, m_ar, m_en};
      2'd1: m_rdata = m_period;
      2'd2: m_rdata = m_count;
      default: m_rdata = {29'd0, m_ovr, m_insvc, m_pend};
    endcase
  end

  // Per-cycle compare and pulse log.
  always @(negedge clk) begin
    check("model_epce", epce, m_epce);
    check("model_pend", int_pending, m_pend);
    check("model_insvc", in_service, m_insvc);
    check("model_rdata", cfg_rdata, m_rdata);
    if (epce === 1'b1) pulses.push_back(cyc);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick(1);
    cfg_we = 1'b0; cfg_wdata = '0;
  endtask

  task automatic rd_check(input string nm, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    check(nm, cfg_rdata, exp);
  endtask

  task automatic do_reset();
    rst = 1'b0; cfg_we = 1'b0; cfg_wdata = '0; eret = 1'b0; stall = 1'b0;
    tick(2);
    rst = 1'b1;
    pulses.delete();
  endtask

  task automatic check_pulses(input string nm, input int n, input int p0, input int p1, input int p2);
    int exp[3];
    exp[0] = p0; exp[1] = p1; exp[2] = p2;
    check({nm, "_count"}, pulses.size(), n);
    for (int k = 0; k < n && k < pulses.size(); k++) check({nm, "_time"}, pulses[k], exp[k]);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    do_reset();
    check("rst_epce", epce, 1'b0);
    rd_check("rst_ctrl", 2'd0, 32'd0);
    rd_check("rst_period", 2'd1, RST_PERIOD);
    rd_check("rst_count", 2'd2, 32'd0);
    rd_check("rst_status", 2'd3, 32'd0);

    // Basic auto-reload fire, eret one cycle after each pulse
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'd3);
    t0 = cyc;
    for (int i = 0; i < 20; i++) begin
      eret = (i == 7 || i == 12 || i == 17);
      cfg_addr = 2'd2;
      if (i == 5 || i == 10 || i == 15) begin
        #1;
        check("basic_count_zero", cfg_rdata, 32'd0);
      end
      tick(1);
    end
    eret = 1'b0;
    check_pulses("basic", 3, t0 + 6, t0 + 11, t0 + 16);

    // One-shot
    do_reset();
    wr(2'd1, 32'd4);
    wr(2'd0, 32'd1);
    t0 = cyc;
    for (int i = 0; i < 60; i++) begin
      eret = (i == 6);
      tick(1);
    end
    eret = 1'b0;
    rd_check("oneshot_ctrl", 2'd0, 32'd0);
    check_pulses("oneshot", 1, t0 + 5, 0, 0);

    // Stall deferral
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'd1);
    t0 = cyc;
    for (int i = 0; i < 15; i++) begin
      stall = (i >= 3 && i <= 9);
      if (i == 8) begin
        #1;
        check("stall_pend", int_pending, 1'b1);
        check("stall_epce", epce, 1'b0);
      end
      tick(1);
    end
    stall = 1'b0;
    check_pulses("stall", 1, t0 + 11, 0, 0);

    // Overrun, eret withheld
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd3);
    t0 = cyc;
    for (int i = 0; i < 25; i++) begin
      eret = (i == 15);
      cfg_we = 1'b0; cfg_wdata = '0;
      if (i == 12) rd_check("ovr_status_111", 2'd3, 32'd7);
      if (i == 18) begin cfg_we = 1'b1; cfg_addr = 2'd0; cfg_wdata = 32'd0; end
      if (i == 19) begin cfg_we = 1'b1; cfg_addr = 2'd3; cfg_wdata = 32'd5; end
      if (i == 20) rd_check("ovr_status_w1c", 2'd3, 32'd2);
      tick(1);
    end
    eret = 1'b0; cfg_we = 1'b0;
    check_pulses("ovr", 2, t0 + 4, t0 + 17, 0);

    // PERIOD=0 with EN=1
    do_reset();
    wr(2'd0, 32'd3);
    tick(20);
    rd_check("p0_count", 2'd2, 32'd0);
    rd_check("p0_ctrl", 2'd0, 32'd3);
    check_pulses("p0", 0, 0, 0, 0);

    // PERIOD write on the match cycle
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'd1);
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      cfg_we = (i == 4);
      cfg_addr = (i == 4) ? 2'd1 : 2'd2;
      cfg_wdata = (i == 4) ? 32'd9 : 32'd0;
      if (i == 5) begin
        #1;
        check("pwr_count", cfg_rdata, 32'd0);
      end
      tick(1);
    end
    cfg_we = 1'b0;
    rd_check("pwr_period", 2'd1, 32'd9);
    check_pulses("pwr", 1, t0 + 6, 0, 0);

    // Asynchronous reset during FIRE
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'd3);
    t0 = cyc;
    while (cyc < t0 + 6) tick(1);
    check("fire_epce", epce, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_epce", epce, 1'b0);
    check("arst_pend", int_pending, 1'b0);
    check("arst_insvc", in_service, 1'b0);
    rd_check("arst_ctrl", 2'd0, 32'd0);
    rd_check("arst_period", 2'd1, RST_PERIOD);
    rd_check("arst_count", 2'd2, 32'd0);
    rd_check("arst_status", 2'd3, 32'd0);
    tick(1);
    rst = 1'b1;
    pulses.delete();
    tick(30);
    check_pulses("arst_quiet", 0, 0, 0, 0);
    rd_check("arst_ctrl_after", 2'd0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_int_ctrl.md
Name: timer_int_ctrl

Overview:
Timer interrupt source for the five-stage pipeline. It counts cycles against a programmable period and raises a one-cycle epce pulse. The register file uses that pulse to capture the return address into r26. The block also tracks interrupt pending and in-service state until an eret arrives from ID. It is configured through a small register window written from the WB stage.

Parameters:
CNT_W, 32, width of COUNT and PERIOD registers
RST_PERIOD, 32'd0, PERIOD value after reset (0 = timer never fires)

Ports:
clk  in  1  system clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-low (0 = reset)
cfg_we  in  1  register write strobe from WB
cfg_addr  in  2  register select: 0 CTRL, 1 PERIOD, 2 COUNT, 3 STATUS
cfg_wdata  in  CNT_W  write data
cfg_rdata  out  CNT_W  combinational read of the register selected by cfg_addr
eret  in  1  return-from-interrupt, one-cycle strobe from ID
stall  in  1  pipeline stalled; interrupt delivery is deferred while high
epce  out  1  one-cycle pulse at TIMER_INT_STATUS level when the interrupt is taken
int_pending  out  1  STATUS[0]
in_service  out  1  STATUS[1]

Behaviour:
- Reset (rst=0, async): CTRL=0, PERIOD=RST_PERIOD, COUNT=0, STATUS=0, epce=0. State goes to IDLE. A reset asserted mid-operation aborts everything, including a pulse in flight.
- CTRL: bit0 EN, bit1 AUTO_RELOAD; the other bits read 0. COUNT is read-only; writes to it are ignored.
- STATUS: bit0 PEND, bit1 INSVC, bit2 OVR (sticky overrun). Writing 1 clears PEND or OVR; writing 0 has no effect. INSVC is not writable.
- Counting:
  - While EN=1 and PERIOD!=0, COUNT increments by 1 each cycle.
  - Match occurs when COUNT==PERIOD-1. On the match cycle, COUNT goes to 0 on the next edge.
  - If AUTO_RELOAD=0, EN is cleared by hardware at the match.
  - PERIOD=0 disables matching; COUNT holds.
- Match effect: PEND is set. If PEND is already 1, OVR is set instead; interrupts do not queue.
- State machine:
  - IDLE: EN=0. Goes to RUN when EN is written to 1.
  - RUN: counting. Goes to WAIT on a match.
  - WAIT: PEND=1. Goes to FIRE once stall=0 and INSVC=0.
  - FIRE: one cycle. epce=1, PEND cleared, INSVC set, then goes to SVC.
  - SVC: waits for eret. eret clears INSVC. Next state is WAIT if PEND=1, else RUN if EN=1, else IDLE.
- Counting continues in every state while EN=1. A match in SVC sets PEND only; its pulse is delivered after eret.
- Latency: a match on cycle N with stall=0 and INSVC=0 gives epce=1 on cycle N+2. A stalled delivery fires on the first cycle after stall falls, plus 1.
- epce is never high on two consecutive cycles. epce is never high while INSVC was already 1.
- Simultaneous events:
  - PERIOD write on a match cycle: the match uses the old PERIOD, and COUNT goes to 0.
  - Any PERIOD write resets COUNT to 0.
  - eret together with a new match: INSVC clears, PEND sets, and the pulse comes no earlier than the next cycle.
  - W1C of PEND in the same cycle as a match: the match wins and PEND stays 1.
  - EN cleared while in WAIT: the pending interrupt is still delivered.
- Width rule: COUNT wraps modulo 2^CNT_W. PERIOD-1 is computed in CNT_W bits, so it is never evaluated when PERIOD=0.

Decomposition:
- Shared DEFINE package gets: TIMER_INT_STATUS, the CTRL/STATUS bit positions, the cfg_addr codes (TMR_CTRL, TMR_PERIOD, TMR_COUNT, TMR_STATUS), and the 3-bit state encodings.
- One natural sub-module, timer_counter: EN, PERIOD and COUNT with match and reload, outputting a match strobe.
- The FSM, STATUS register and read mux stay in timer_int_ctrl.

Test Plan:
- Basic fire: PERIOD=5, CTRL=3, stall=0 → epce pulses on cycles 6, 11, 16 after the enable write when eret is given 1 cycle after each pulse; COUNT reads 0 on each match+1 cycle.
- One-shot: PERIOD=4, CTRL=1 → single epce; CTRL reads 0 afterwards; no further pulse in 50 cycles.
- Stall deferral: match while stall=1 for 7 cycles → epce low throughout, int_pending=1; epce=1 exactly 1 cycle after stall falls.
- Overrun: PERIOD=3, CTRL=3, eret withheld 10 cycles → one epce; STATUS reads 3'b111; after eret, one more epce; W1C 3'b101 leaves STATUS=3'b010.
- Edge cases: PERIOD=0 with EN=1 → COUNT stays 0 and no epce. A PERIOD write in the match cycle → the match still fires and COUNT=0.
- Reset mid-operation: rst=0 asynchronously during FIRE → epce drops immediately; all registers read 0, PERIOD=RST_PERIOD; no pulse after release until reprogrammed.
